// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece sequencer.
package tetris_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    SPAWN,
    IDLE,
    CHECK,
    LOCK,
    OVER
  } state_t;

  // Kind of move currently being checked; it decides the outcome of a hit
  typedef enum logic [2:0] {
    ACT_SPAWN,
    ACT_GRAV,
    ACT_DOWN,
    ACT_SIDE,
    ACT_ROT
  } act_t;

  // Piece codes
  localparam logic [2:0] PIECE_I = 3'd0;
  localparam logic [2:0] PIECE_O = 3'd1;
  localparam logic [2:0] PIECE_T = 3'd2;
  localparam logic [2:0] PIECE_S = 3'd3;
  localparam logic [2:0] PIECE_Z = 3'd4;
  localparam logic [2:0] PIECE_J = 3'd5;
  localparam logic [2:0] PIECE_L = 3'd6;

  // Board geometry in cells
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  // One piece pose: column, row, rotation and piece code
  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] rot;
    logic [2:0] block;
  } pose_t;

endpackage

// File: rtl/piece_lfsr.sv
// Free-running 3-bit maximal LFSR producing piece codes 0..6.
module piece_lfsr (
  input  logic       pclk,
  input  logic       rst,
  output logic [2:0] code
);

  logic [2:0] q;

  // Advance x^3 + x^2 + 1 every clock; period 7 over the non-zero states
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) q <= 3'b001;
    else     q <= {q[1:0], q[2] ^ q[1]};
  end

  // The LFSR never reaches 0, so 7 folds onto code 0 to cover all seven pieces
  assign code = (q == 3'd7) ? 3'd0 : q;

endmodule

// File: rtl/piece_seq_ctl.sv
// Piece sequencer: spawns pieces, turns buttons and gravity into candidate
// moves, asks the collision checker about each one and commits or locks.
module piece_seq_ctl
  import tetris_pkg::*;
#(
  parameter int GRAVITY_FRAMES = 30,
  parameter int SPAWN_X        = 4,
  parameter int SPAWN_Y        = 0
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  input  logic       btnU,
  input  logic       vsync,
  output logic       chk_req,
  output logic [4:0] chk_xpos,
  output logic [4:0] chk_ypos,
  output logic [1:0] chk_rot,
  output logic [2:0] chk_block,
  input  logic       chk_done,
  input  logic       chk_hit,
  output logic [4:0] xpos,
  output logic [4:0] ypos,
  output logic [1:0] rot,
  output logic [2:0] block,
  output logic       lock,
  output logic       game_over
);

  localparam int CW = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;

  // Pending-flag bit positions; also the button order in btn_now
  localparam int P_D = 0;
  localparam int P_R = 1;
  localparam int P_L = 2;
  localparam int P_U = 3;
  localparam int P_G = 4;

  localparam pose_t SPAWN_POSE = '{x: 5'(SPAWN_X), y: 5'(SPAWN_Y), rot: 2'd0, block: 3'd0};

  state_t        state, state_nxt;
  act_t          act, svc_act;
  pose_t         cur, cand, svc_pose;
  logic [4:0]    pend, svc_clr, new_ev;
  logic [3:0]    btn_now, btn_q;
  logic          vsync_q, vs_rise, grav_exp, done_ok, down_commit;
  logic [CW-1:0] grav_cnt;
  logic [2:0]    code;

  piece_lfsr u_lfsr (
    .pclk (pclk),
    .rst  (rst),
    .code (code)
  );

  assign btn_now  = {btnU, btnL, btnR, btnD};
  assign vs_rise  = vsync & ~vsync_q;
  // A chk_done outside an outstanding request (e.g. around reset) is stale
  assign done_ok  = chk_req & chk_done;
  assign grav_exp = vs_rise && (grav_cnt == CW'(GRAVITY_FRAMES - 1)) && (state != OVER);
  assign new_ev   = (state == OVER) ? 5'd0 : {grav_exp, btn_now & ~btn_q};
  assign down_commit = (state == CHECK) && done_ok && !chk_hit && (act == ACT_DOWN);

  // State register
  always_ff @(posedge pclk) begin
    if (rst) state <= SPAWN;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_nxt = state;
    unique case (state)
      SPAWN: state_nxt = CHECK;
      IDLE:  if (|pend) state_nxt = CHECK;
      CHECK: begin
        if (done_ok) begin
          if (!chk_hit)                                  state_nxt = IDLE;
          else if (act == ACT_SPAWN)                     state_nxt = OVER;
          else if (act == ACT_GRAV || act == ACT_DOWN)   state_nxt = LOCK;
          else                                           state_nxt = IDLE;
        end
      end
      LOCK:  state_nxt = SPAWN;
      OVER:  state_nxt = OVER;
      default: state_nxt = SPAWN;
    endcase
  end

  // Pick the highest-priority pending event and form its candidate pose
  always_comb begin
    svc_act  = ACT_GRAV;
    svc_clr  = '0;
    svc_pose = cur;
    if (pend[P_G]) begin
      svc_act = ACT_GRAV;  svc_clr[P_G] = 1'b1; svc_pose.y   = cur.y + 5'd1;
    end else if (pend[P_U]) begin
      svc_act = ACT_ROT;   svc_clr[P_U] = 1'b1; svc_pose.rot = cur.rot + 2'd1;
    end else if (pend[P_L]) begin
      svc_act = ACT_SIDE;  svc_clr[P_L] = 1'b1; svc_pose.x   = cur.x - 5'd1;
    end else if (pend[P_R]) begin
      svc_act = ACT_SIDE;  svc_clr[P_R] = 1'b1; svc_pose.x   = cur.x + 5'd1;
    end else if (pend[P_D]) begin
      svc_act = ACT_DOWN;  svc_clr[P_D] = 1'b1; svc_pose.y   = cur.y + 5'd1;
    end
  end

  // Datapath: event capture, gravity count, candidate and committed pose
  always_ff @(posedge pclk) begin
    if (rst) begin
      cur      <= SPAWN_POSE;
      cand     <= SPAWN_POSE;
      act      <= ACT_SPAWN;
      chk_req  <= 1'b0;
      pend     <= '0;
      btn_q    <= '0;
      vsync_q  <= 1'b0;
      grav_cnt <= '0;
    end else begin
      btn_q   <= btn_now;
      vsync_q <= vsync;
      // Request rises one cycle after entering CHECK and drops with the answer
      chk_req <= (state == CHECK) && !done_ok;

      if (state == LOCK)
        pend <= '0;
      else
        pend <= (pend & ~((state == IDLE) ? svc_clr : 5'd0)) | new_ev;

      if (state != OVER) begin
        if (grav_exp)         grav_cnt <= '0;
        else if (down_commit) grav_cnt <= '0;
        else if (vs_rise)     grav_cnt <= grav_cnt + 1'b1;
      end

      if (state == SPAWN) begin
        cand <= '{x: 5'(SPAWN_X), y: 5'(SPAWN_Y), rot: 2'd0, block: code};
        act  <= ACT_SPAWN;
      end else if (state == IDLE && |pend) begin
        cand <= svc_pose;
        act  <= svc_act;
      end

      if (state == CHECK && done_ok && !chk_hit)
        cur <= cand;
    end
  end

  assign chk_xpos  = cand.x;
  assign chk_ypos  = cand.y;
  assign chk_rot   = cand.rot;
  assign chk_block = cand.block;
  assign xpos      = cur.x;
  assign ypos      = cur.y;
  assign rot       = cur.rot;
  assign block     = cur.block;
  assign lock      = (state == LOCK);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_piece_seq_ctl.sv
// Scoreboard bench for piece_seq_ctl: stimulus queues the expected checker
// requests, a monitor pops them as each chk_req rises, and a responder plays
// the collision checker against a simple board model.
module tb_piece_seq_ctl;

  typedef struct {
    int x;
    int y;
    int rot;
    int blk;   // -1: any legal piece code
  } exp_t;

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic       btnL = 1'b0, btnR = 1'b0, btnD = 1'b0, btnU = 1'b0, vsync = 1'b0;
  logic       chk_req, chk_done, chk_hit;
  logic       resp_done = 1'b0, stray_done = 1'b0;
  logic [4:0] chk_xpos, chk_ypos, xpos, ypos;
  logic [1:0] chk_rot, rot;
  logic [2:0] chk_block, block;
  logic       lock, game_over;

  exp_t exp_q[$];
  int   total = 0, passed = 0;
  int   lock_cnt = 0, lock_y = -1;
  bit   resp_en = 1'b1, spawn_blocked = 1'b0;
  int   floor_y = 20;

  assign chk_done = resp_done | stray_done;

  piece_seq_ctl #(.GRAVITY_FRAMES(2), .SPAWN_X(4), .SPAWN_Y(0)) dut (
    .pclk(pclk), .rst(rst),
    .btnL(btnL), .btnR(btnR), .btnD(btnD), .btnU(btnU), .vsync(vsync),
    .chk_req(chk_req), .chk_xpos(chk_xpos), .chk_ypos(chk_ypos),
    .chk_rot(chk_rot), .chk_block(chk_block),
    .chk_done(chk_done), .chk_hit(chk_hit),
    .xpos(xpos), .ypos(ypos), .rot(rot), .block(block),
    .lock(lock), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic push(input int x, input int y, input int r, input int b);
    exp_t e;
    e.x = x; e.y = y; e.rot = r; e.blk = b;
    exp_q.push_back(e);
  endtask

  // Board model: walls at column >= 10, floor at floor_y, optional blocked spawn row
  function automatic logic board_hit();
    return (chk_xpos >= 5'd10) || (int'(chk_ypos) >= floor_y) ||
           (spawn_blocked && chk_ypos == 5'd0);
  endfunction

  // Collision-checker model: answers two cycles after each request rises
  initial begin
    int age = 0;
    chk_hit = 1'b0;
    forever begin
      @(posedge pclk); #1;
      if (resp_en) begin
        resp_done = 1'b0;
        chk_hit   = 1'b0;
        if (chk_req) begin
          age++;
          if (age == 2) begin
            resp_done = 1'b1;
            chk_hit   = board_hit();
            age       = 0;
          end
        end else age = 0;
      end else age = 0;
    end
  end

  // Monitor: compare each new request against the scoreboard
  initial begin
    logic req_q = 1'b0;
    exp_t e;
    forever begin
      @(negedge pclk);
      if (chk_req && !req_q) begin
        if (exp_q.size() == 0) check("unexpected_req", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("req_x", int'(chk_xpos), e.x);
          check("req_y", int'(chk_ypos), e.y);
          check("req_rot", int'(chk_rot), e.rot);
          if (e.blk >= 0) check("req_blk", int'(chk_block), e.blk);
          else            check("req_blk_range", int'(chk_block <= 3'd6), 1);
        end
      end
      req_q = chk_req;
    end
  end

  // Lock pulse monitor
  initial forever begin
    @(negedge pclk);
    if (lock) begin
      lock_cnt++;
      lock_y = int'(ypos);
    end
  end

  // Wait until no request or lock activity for several cycles
  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 6 && n < 300) begin
      @(negedge pclk);
      n++;
      if (chk_req || lock) quiet = 0; else quiet++;
    end
    if (quiet < 6) check("idle_timeout", n, 0);
  endtask

  task automatic press(input int which);
    case (which)
      0: btnL = 1'b1;
      1: btnR = 1'b1;
      2: btnD = 1'b1;
      default: btnU = 1'b1;
    endcase
    @(posedge pclk); #1;
    {btnL, btnR, btnD, btnU} = 4'b0;
    wait_idle();
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    @(posedge pclk); #1;
    vsync = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, int'(chk_req), 0);
    check({tag, "_x"}, int'(xpos), 4);
    check({tag, "_y"}, int'(ypos), 0);
    check({tag, "_rot"}, int'(rot), 0);
    check({tag, "_blk"}, int'(block), 0);
    check({tag, "_lock"}, int'(lock), 0);
    check({tag, "_over"}, int'(game_over), 0);
  endtask

  initial begin
    // Reset state, then the first spawn (LFSR seed 001 gives piece 1)
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_reset_outputs("rst");
    push(4, 0, 0, 1);
    @(posedge pclk); #1;
    rst = 1'b0;
    wait_idle();
    check("spawn_x", int'(xpos), 4);
    check("spawn_y", int'(ypos), 0);
    check("spawn_rot", int'(rot), 0);
    check("spawn_blk", int'(block), 1);
    check("spawn_nolock", lock_cnt, 0);

    // Gravity after two frames
    push(4, 1, 0, 1);
    pulse_vsync();
    pulse_vsync();
    wait_idle();
    check("grav_y", int'(ypos), 1);

    // Gravity, rotate and left arriving together are all serviced in order
    pulse_vsync();
    push(4, 2, 0, 1);
    push(4, 2, 1, 1);
    push(3, 2, 1, 1);
    vsync = 1'b1; btnU = 1'b1; btnL = 1'b1;
    @(posedge pclk); #1;
    vsync = 1'b0; btnU = 1'b0; btnL = 1'b0;
    wait_idle();
    check("multi_x", int'(xpos), 3);
    check("multi_y", int'(ypos), 2);
    check("multi_rot", int'(rot), 1);

    // Walk to column 0, then a blocked left move wraps to 31 and is discarded
    for (int x = 2; x >= 0; x--) begin
      push(x, 2, 1, 1);
      press(0);
    end
    push(31, 2, 1, 1);
    press(0);
    check("wall_x", int'(xpos), 0);
    check("wall_nolock", lock_cnt, 0);

    // Soft drop to row 18 with the floor at 19
    floor_y = 19;
    for (int y = 3; y <= 18; y++) begin
      push(0, y, 1, 1);
      press(2);
    end
    check("drop_y", int'(ypos), 18);
    check("drop_nolock", lock_cnt, 0);

    // Down move hits: lock at row 18, blocked spawn ends the game
    spawn_blocked = 1'b1;
    push(0, 19, 1, 1);
    push(4, 0, 0, -1);
    press(2);
    check("lock_cnt", lock_cnt, 1);
    check("lock_y", lock_y, 18);
    check("over_set", int'(game_over), 1);
    check("over_y", int'(ypos), 18);

    // Game over ignores buttons and frames
    press(0);
    press(3);
    pulse_vsync();
    pulse_vsync();
    wait_idle();
    check("over_hold", int'(game_over), 1);
    check("over_x", int'(xpos), 0);
    check("over_lockcnt", lock_cnt, 1);

    // Reset clears the game over
    rst = 1'b1;
    spawn_blocked = 1'b0;
    floor_y = 20;
    resp_en = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check_reset_outputs("rst2");

    // Reset while a request is outstanding; stray chk_done is ignored
    push(4, 0, 0, -1);
    rst = 1'b0;
    begin
      int n = 0;
      while (!chk_req && n < 20) begin
        @(negedge pclk);
        n++;
      end
    end
    check("req_pending", int'(chk_req), 1);
    rst = 1'b1;
    stray_done = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check_reset_outputs("rst3");
    push(4, 0, 0, -1);
    rst = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check("stray_noreq", int'(chk_req), 0);
    stray_done = 1'b0;
    resp_en = 1'b1;
    wait_idle();
    check("respawn_x", int'(xpos), 4);
    check("respawn_y", int'(ypos), 0);
    check("respawn_blk", int'(block <= 3'd6), 1);
    check("respawn_over", int'(game_over), 0);
    check("respawn_nolock", lock_cnt, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piece_seq_ctl.md
PIECE_SEQ_CTL -- requirements
Module: piece_seq_ctl

Interface
REQ-001 Parameter GRAVITY_FRAMES, default 30: frames per automatic one-row drop.
REQ-002 Parameter SPAWN_X, default 4: spawn column.
REQ-003 Parameter SPAWN_Y, default 0: spawn row.
REQ-004 pclk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 btnL, btnR, btnD, btnU  in  1 each  level buttons (left, right, soft-drop, rotate), already synchronized to pclk.
REQ-007 vsync  in  1  frame sync from the timing chain; its rising edge is one frame tick.
REQ-008 chk_req  out  1  request to the collision checker to test the candidate pose.
REQ-009 chk_xpos, chk_ypos  out  5 each  candidate column/row; chk_rot  out  2  candidate rotation; chk_block  out  3  candidate piece.
REQ-010 chk_done  in  1  one-cycle pulse: checker result valid; chk_hit  in  1  candidate overlaps walls, floor or fallen blocks, sampled only with chk_done.
REQ-011 xpos, ypos  out  5 each; rot  out  2; block  out  3  committed pose driving the piece renderer.
REQ-012 lock  out  1  one-cycle pulse: the committed pose is final; game_over  out  1  level.

Function
REQ-013 FSM states SHALL be SPAWN, IDLE, CHECK, LOCK, OVER.
REQ-014 SPAWN SHALL load the candidate with SPAWN_X, SPAWN_Y, rot 0 and the next piece code, then enter CHECK.
REQ-015 In IDLE, a rising edge on any button or a gravity expiry SHALL set a pending flag; flags hold until serviced, so no event is lost while in CHECK.
REQ-016 Servicing priority when several flags are set: gravity, then btnU, then btnL, then btnR, then btnD; one action per CHECK.
REQ-017 Candidate formation: gravity/btnD gives ypos+1; btnL gives xpos-1; btnR gives xpos+1; btnU gives rot+1. Arithmetic is modulo 2^width; 0-1=31 is an out-of-board column that the checker reports as a hit.
REQ-018 chk_req SHALL rise the cycle after CHECK entry and stay high, with the chk_* pose stable, until the cycle chk_done is sampled; it is low in every other state.
REQ-019 If chk_hit=0, the candidate SHALL be committed to xpos/ypos/rot/block on the cycle after chk_done, and the FSM returns to IDLE.
REQ-020 If chk_hit=1: a lateral or rotate move is discarded and the FSM returns to IDLE; a down move (gravity or btnD) goes to LOCK; a spawn check goes to OVER.
REQ-021 LOCK SHALL pulse lock for exactly one cycle with the committed pose unchanged, clear all pending flags, then enter SPAWN.
REQ-022 The gravity counter SHALL count vsync rising edges; at GRAVITY_FRAMES it sets the gravity flag and clears to 0. A successful btnD commit also clears it.
REQ-023 Piece codes SHALL come from a 3-bit maximal LFSR that advances every pclk; value 7 maps to 0, giving codes 0..6.
REQ-024 OVER SHALL hold game_over=1 and ignore all inputs until rst.

Reset
REQ-025 While rst=1 at a clock edge: state=SPAWN, xpos=SPAWN_X, ypos=SPAWN_Y, rot=0, block=0, chk_req=0, lock=0, game_over=0, pending flags=0, gravity counter=0, LFSR seed=3'b001.
REQ-026 A reset asserted during CHECK SHALL drop chk_req on the next edge; a chk_done arriving during or after reset SHALL be ignored until SPAWN re-issues chk_req.

Structure
REQ-027 The shared package tetris_pkg SHALL hold the FSM state enum, piece code constants (I,O,T,S,Z,J,L = 0..6), board width 10 and board height 20.
REQ-028 The LFSR SHALL be a sub-module, piece_lfsr (ports: pclk, rst, code[2:0]).

Verification
REQ-029 After reset release with chk_done returning chk_hit=0 two cycles after chk_req: xpos=4, ypos=0, rot=0, FSM in IDLE, lock never pulsed.
REQ-030 GRAVITY_FRAMES=2, with 2 vsync rising edges and hit=0: exactly one chk_req with chk_ypos=1, and ypos=1 one cycle after chk_done.
REQ-031 btnU and btnL rising on the same cycle as a gravity expiry: three sequential checks in the order ypos+1, rot+1, xpos-1, with no event dropped.
REQ-032 At xpos=0, btnL is pressed and the checker returns hit on chk_xpos=31: xpos stays 0, no lock.
REQ-033 A down move returns hit at ypos=18: one lock pulse with ypos=18, then SPAWN issues a new chk_req with chk_ypos=0; if that spawn check hits, game_over=1 and persists until rst.
REQ-034 rst asserted while chk_req=1: chk_req=0 on the next edge and all outputs at their reset values.
